wav_capture_trig: RTL
=====================

Name: wav_capture_trig

Overview:
- Write-side front end for the waveform display buffer: it takes decimated ADC samples and writes them into the 1024-entry dual-port sample RAM.
- A circular pre-trigger and post-trigger capture is wrapped around a level/edge trigger.
- When a frame is complete it publishes the display start address and waits for the display reader to release the buffer before re-arming.
- Sits between the ADC interface and the display RAM write port, in the ADC clock domain.

Parameters:
ADDR_W, 10, RAM address width; buffer depth DEPTH = 2**ADDR_W
PRE_LEN, 256, number of samples kept before the trigger point (1..DEPTH-1)
AUTO_TO, 4096, accepted samples without a trigger before auto mode forces one
HOLDOFF, 16, idle clk cycles in DONE before a re-arm is allowed

Ports:
clk  in  1  ADC/sample clock
rst_n  in  1  asynchronous active-low reset
ad_data  in  8  ADC sample, offset binary (127 = zero)
ad_valid  in  1  ad_data is valid this cycle
decim  in  8  keep 1 of every decim+1 valid samples
trig_level  in  8  trigger threshold
trig_edge  in  1  0 = rising, 1 = falling
trig_mode  in  1  0 = auto, 1 = normal
stop  in  1  freeze: do not start a new capture
disp_busy  in  1  display is reading the buffer; re-arm is blocked while high
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  8  RAM write data
start_addr  out  ADDR_W  address of the oldest sample in the last frame (display read base)
cap_done  out  1  one-cycle pulse when a frame completes
triggered  out  1  high from trigger detection until the frame completes
armed  out  1  high in ARM state

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; decimation counter, sample counter, address pointer, prev-sample valid flag and holdoff counter all cleared.
- Accept strobe: acc = ad_valid && (dcnt == decim).
  - dcnt increments on each ad_valid and clears on acc.
  - decim=0 means every valid sample is accepted.
  - dcnt clears whenever the state is IDLE.
- Write: on each acc in PRE, ARM or POST, the next clk edge drives wr_en=1, wr_data=ad_data and wr_addr=ptr. ptr then increments modulo DEPTH. Latency is 1 cycle, and there is never more than one write per acc.
- Trigger detect uses prev, the last accepted sample, and is only valid once one accepted sample exists since entering ARM.
  - Rising: prev < trig_level && ad_data >= trig_level.
  - Falling: prev > trig_level && ad_data <= trig_level.
  - Compares are unsigned 8-bit.
- IDLE:
  - if !stop && !disp_busy: go to PRE and clear cnt.
  - ptr is not reset, so the buffer wraps continuously.
- PRE:
  - cnt counts accepted samples.
  - When cnt reaches PRE_LEN-1 on an acc: go to ARM and clear cnt and the prev-valid flag.
  - stop=1: go to IDLE; the current-cycle acc is still written.
- ARM:
  - armed=1; writes continue circularly, overwriting the oldest pre-trigger data.
  - On an acc with the trigger condition true: trig_addr=ptr (the address of this sample), triggered=1, go to POST, cnt=1.
  - Auto mode: if AUTO_TO accepted samples pass with no trigger, force the trigger on the next acc.
  - Normal mode: wait indefinitely.
  - stop=1: go to IDLE.
- POST:
  - Writes DEPTH-PRE_LEN samples in total, counting the trigger sample.
  - On the final acc: start_addr = (trig_addr - PRE_LEN) mod DEPTH, cap_done pulses on the following cycle, triggered=0, go to DONE.
  - stop is ignored in POST; the frame always completes.
- DONE:
  - No writes; the holdoff counter counts HOLDOFF cycles.
  - Then: if stop=1, go to IDLE and hold there; else if disp_busy=0, go to PRE; otherwise wait.
- Simultaneous events:
  - A trigger on the same acc as the AUTO_TO expiry counts as a real trigger, with the same behaviour.
  - stop and the trigger in the same cycle in ARM: the trigger wins and the block goes to POST.
- start_addr only updates at frame completion and is stable otherwise.
- Reset mid-frame drops the frame: no cap_done, and start_addr returns to 0.

Test Plan:
1. Ramp 0..255 repeating, ad_valid=1, decim=0, trig_level=100, rising, normal mode -> cap_done after 256 pre + trigger + 767 post samples; the RAM at start_addr+256 holds 100; start_addr = trig_addr-256 mod 1024.
2. Constant ad_data=50, auto mode, AUTO_TO=4096 -> forced trigger after 4096 accepted samples in ARM; cap_done pulses, then re-arm after HOLDOFF cycles.
3. decim=3, ad_valid=1 every cycle -> wr_en asserted every 4th cycle; the written values are every 4th input sample.
4. disp_busy held high across the end of DONE -> no write and no PRE entry until disp_busy drops, then PRE on the next cycle.
5. stop asserted during ARM -> IDLE next cycle, wr_en=0 thereafter. stop asserted during POST -> the frame completes with cap_done, then IDLE.
6. rst_n pulsed low mid-POST -> all outputs 0 immediately (asynchronously), no cap_done; after release, a capture restarts only from IDLE.

Source files
------------

// File: rtl/wav_capture_trig.sv
// Write-side capture front end for the waveform display buffer: decimates ADC samples,
// keeps a circular pre-trigger window, detects a level/edge trigger and publishes each frame.
module wav_capture_trig #(
    parameter int ADDR_W  = 10,
    parameter int PRE_LEN = 256,
    parameter int AUTO_TO = 4096,
    parameter int HOLDOFF = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ad_data,
    input  logic              ad_valid,
    input  logic [7:0]        decim,
    input  logic [7:0]        trig_level,
    input  logic              trig_edge,
    input  logic              trig_mode,
    input  logic              stop,
    input  logic              disp_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] start_addr,
    output logic              cap_done,
    output logic              triggered,
    output logic              armed
);

    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int POST_LEN = DEPTH - PRE_LEN;
    localparam int CNT_MAX  = (AUTO_TO > DEPTH) ? AUTO_TO : DEPTH;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int HOLD_W   = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ARM  = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state_r;
    logic [7:0]          dcnt_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [ADDR_W-1:0]   ptr_r;
    logic [ADDR_W-1:0]   trig_addr_r;
    logic [7:0]          prev_r;
    logic                prev_vld_r;
    logic [HOLD_W-1:0]   hold_r;

    logic                acc_s;
    logic                wr_phase_s;
    logic                trig_hit_s;
    logic                force_s;

    // Accept strobe and trigger conditions for the current sample
    always_comb begin
        acc_s      = ad_valid && (dcnt_r == decim);
        wr_phase_s = (state_r == ST_PRE) || (state_r == ST_ARM) || (state_r == ST_POST);
        force_s    = !trig_mode && (cnt_r >= CNT_W'(AUTO_TO));
        if (!prev_vld_r) begin
            trig_hit_s = 1'b0;
        end else if (trig_edge) begin
            trig_hit_s = (prev_r > trig_level) && (ad_data <= trig_level);
        end else begin
            trig_hit_s = (prev_r < trig_level) && (ad_data >= trig_level);
        end
    end

    // Decimation counter, held clear while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_r <= 8'd0;
        end else if (state_r == ST_IDLE) begin
            dcnt_r <= 8'd0;
        end else if (acc_s) begin
            dcnt_r <= 8'd0;
        end else if (ad_valid) begin
            dcnt_r <= dcnt_r + 8'd1;
        end
    end

    // Capture FSM with registered RAM write port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            ptr_r       <= '0;
            trig_addr_r <= '0;
            prev_r      <= 8'd0;
            prev_vld_r  <= 1'b0;
            hold_r      <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 8'd0;
            start_addr  <= '0;
            cap_done    <= 1'b0;
            triggered   <= 1'b0;
            armed       <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            cap_done <= 1'b0;
            if (acc_s && wr_phase_s) begin
                wr_en   <= 1'b1;
                wr_addr <= ptr_r;
                wr_data <= ad_data;
                ptr_r   <= ptr_r + 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (!stop && !disp_busy) begin
                        state_r <= ST_PRE;
                        cnt_r   <= '0;
                    end
                end
                ST_PRE: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                    end else if (acc_s) begin
                        if (cnt_r == CNT_W'(PRE_LEN - 1)) begin
                            state_r    <= ST_ARM;
                            armed      <= 1'b1;
                            cnt_r      <= '0;
                            prev_vld_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    // A trigger on this sample outranks a simultaneous stop
                    if (acc_s && (trig_hit_s || force_s)) begin
                        trig_addr_r <= ptr_r;
                        triggered   <= 1'b1;
                        armed       <= 1'b0;
                        state_r     <= ST_POST;
                        cnt_r       <= CNT_W'(1);
                    end else if (stop) begin
                        state_r <= ST_IDLE;
                        armed   <= 1'b0;
                    end else if (acc_s) begin
                        prev_r     <= ad_data;
                        prev_vld_r <= 1'b1;
                        if (cnt_r != CNT_W'(AUTO_TO)) begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                ST_POST: begin
                    if (acc_s) begin
                        if (cnt_r == CNT_W'(POST_LEN - 1)) begin
                            start_addr <= trig_addr_r - ADDR_W'(PRE_LEN);
                            cap_done   <= 1'b1;
                            triggered  <= 1'b0;
                            state_r    <= ST_DONE;
                            hold_r     <= '0;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (hold_r == HOLD_W'(HOLDOFF)) begin
                        if (stop) begin
                            state_r <= ST_IDLE;
                        end else if (!disp_busy) begin
                            state_r <= ST_PRE;
                            cnt_r   <= '0;
                        end
                    end else begin
                        hold_r <= hold_r + 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    armed     <= 1'b0;
                    triggered <= 1'b0;
                end
            endcase
        end
    end

endmodule
